// File: rtl/fifo_reader.sv
// Read-side agent for the Z-Buffer sample FIFO: issues pop pulses, captures the
// returned words into a small circular buffer, and streams them out via valid/ready.
module fifo_reader #(
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_LENGTH   = 8,
    parameter int READ_LATENCY = 3,
    parameter int BUF_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [MEM_LENGTH-1:0] fifo_fill,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  req_out,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  ovf_err
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    state_t                  r_state;
    logic                    r_req_out;
    logic [READ_LATENCY-1:0] r_pipe;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           r_outst;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_buf [BUF_DEPTH];
    logic                    r_ovf;

    logic w_credit_ok;
    logic w_issue;
    logic w_cap;
    logic w_acc;
    logic w_full;
    logic w_write;

    // Buffered plus in-flight words must leave room for one more pop.
    assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_outst}) < (CW + 1)'(BUF_DEPTH);
    assign w_issue     = (r_state == ISSUE);
    assign w_cap       = r_pipe[READ_LATENCY-1];
    assign w_acc       = m_valid & m_ready;
    assign w_full      = (r_count == CW'(BUF_DEPTH));
    assign w_write     = w_cap & (~w_full | w_acc);

    assign req_out = r_req_out;
    assign m_valid = (r_count != '0);
    assign m_data  = r_buf[r_rd_ptr];
    assign busy    = (r_state != IDLE) | (r_outst != '0) | m_valid;
    assign ovf_err = r_ovf;

    // GAP needs fill >= 2 since the pop just issued is not yet visible in fifo_fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_req_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run && (fifo_fill != '0) && w_credit_ok) begin
                        r_state   <= ISSUE;
                        r_req_out <= 1'b1;
                    end else begin
                        r_req_out <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_state   <= GAP;
                    r_req_out <= 1'b0;
                end
                GAP: begin
                    if (run && (fifo_fill > MEM_LENGTH'(1)) && w_credit_ok) begin
                        r_state   <= ISSUE;
                        r_req_out <= 1'b1;
                    end else begin
                        r_state   <= IDLE;
                        r_req_out <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_req_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe  <= '0;
            r_outst <= '0;
        end else begin
            r_pipe <= {r_pipe[READ_LATENCY-2:0], w_issue};
            case ({w_issue, w_cap})
                2'b10:   r_outst <= r_outst + CW'(1);
                2'b01:   r_outst <= r_outst - CW'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_write) begin
                r_buf[r_wr_ptr] <= fifo_rdata;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_cap && w_full && !w_acc) begin
                r_ovf <= 1'b1;
            end
            if (w_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_write, w_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side agent for the Z-Buffer sample FIFO. Watches the FIFO fill count, issues one-cycle pop pulses on the FIFO `req_out` line, and captures the word the FIFO memory returns a fixed number of cycles later. Captured words go into a local circular buffer drained through a valid/ready stream toward the depth-compare stage. A credit counter guarantees the local buffer never overflows, whatever the downstream backpressure.

## Interface
- `DATA_WIDTH`, 16: FIFO word width.
- `MEM_LENGTH`, 8: FIFO address/fill width; matches the FIFO controller.
- `READ_LATENCY`, 3: cycles from a `req_out` pulse to a valid word on `fifo_rdata`; must be ≥ 2.
- `BUF_DEPTH`, 4: local buffer entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; asserted together with the FIFO controller reset.
- `run`  in  1  enables issuing pops; draining continues when low.
- `fifo_fill`  in  MEM_LENGTH  FIFO occupancy.
- `fifo_rdata`  in  DATA_WIDTH  FIFO memory read data.
- `req_out`  out  1  pop pulse to the FIFO controller (registered).
- `m_valid`  out  1  output word available.
- `m_data`  out  DATA_WIDTH  output word (head of local buffer).
- `m_ready`  in  1  downstream accepts when `m_valid & m_ready`.
- `busy`  out  1  high when state ≠ IDLE, a read is in flight, or the buffer is non-empty.
- `ovf_err`  out  1  sticky: a returned word found the buffer full.

## Operation
- FIFO contract: each one-cycle `req_out` pulse sampled while the FIFO is non-empty pops exactly one word. `fifo_rdata` carries it exactly `READ_LATENCY` cycles after the pulse cycle. `fifo_fill` reflects a pop 2 cycles after the pulse.
- FSM states:
  - IDLE: `req_out`=0. Go to ISSUE when `run & (fifo_fill ≥ 1) & credit_ok`.
  - ISSUE: `req_out`=1 for this cycle only. Always go to GAP.
  - GAP: `req_out`=0. Go to ISSUE when `run & (fifo_fill ≥ 2) & credit_ok`; otherwise go to IDLE.
  - The fill threshold is 2 in GAP because the last pop is not yet reflected in `fifo_fill`.
- Minimum pulse spacing is 2 cycles, giving at most one pop per 2 cycles.
- In-flight pipe: a `READ_LATENCY`-bit shift register with `in_pipe[0]` = (state == ISSUE). The word on `fifo_rdata` is captured in the cycle its tag reaches the last stage.
- `outstanding` = count of set bits in the in-flight pipe, kept as a counter: +1 on ISSUE, −1 on capture, unchanged when both occur.
- `credit_ok` = `count + outstanding < BUF_DEPTH`. `count` is the local buffer occupancy (width log2(BUF_DEPTH)+1).
- Local buffer is a circular buffer with `wr_ptr` and `rd_ptr` (log2(BUF_DEPTH) bits, wrap modulo BUF_DEPTH).
  - Capture writes at `wr_ptr`.
  - A downstream accept advances `rd_ptr`.
  - Capture and accept in the same cycle leave `count` unchanged.
- Outputs: `m_valid` = (count ≠ 0); `m_data` = buf[rd_ptr]. `m_data` must hold stable while `m_valid & !m_ready`.
- Capture with `count == BUF_DEPTH` and no simultaneous accept: drop the word and set `ovf_err`. This is unreachable under a correct contract and exists for assertions. `ovf_err` clears only on reset.
- `run` deasserted in ISSUE: the pulse still completes. The FSM goes to GAP, then IDLE, and in-flight words are still captured.

## Timing
- Reset values: `req_out`=0, `m_valid`=0, `m_data`=0 (buffer cleared), `busy`=0, `ovf_err`=0. State is IDLE; pointers, count, outstanding and in-flight pipe are all 0.
- Reset mid-operation discards in-flight and buffered words. The FIFO is reset in the same cycle, so no stale `fifo_rdata` is captured.
- Pop-to-output latency, from `fifo_fill` ≥ 1 seen in IDLE:
  - ISSUE in cycle t+1.
  - Capture at the end of cycle t+1+READ_LATENCY.
  - `m_valid` high in cycle t+2+READ_LATENCY.
- Sustained throughput is 1 word per 2 cycles. It requires BUF_DEPTH ≥ ceil(READ_LATENCY/2)+1 when `m_ready` is held high.
- With BUF_DEPTH=4, READ_LATENCY=3 and `m_ready`=0: at most 4 pops issue (buffered + outstanding), then the FSM parks in IDLE.

## Test plan
- Single word: `fifo_fill`=1, FIFO model returns 0xBEEF 3 cycles after the pulse → exactly one `req_out` pulse; `m_valid` rises 5 cycles after the IDLE evaluation with `m_data`=0xBEEF; a second pulse only after `fifo_fill` drops to 0 is never issued.
- Streaming: `fifo_fill`=10 with words 1..10, `m_ready`=1 → pulses every 2 cycles, 10 pulses total, outputs 1..10 in order, no gaps beyond 2 cycles, `ovf_err`=0.
- Backpressure: `fifo_fill`=10, `m_ready`=0 → exactly 4 pulses, then `req_out` stays 0 and `m_valid`=1 with `m_data`=1 held stable. Releasing `m_ready` resumes pops, words stay in order, and `ovf_err`=0.
- GAP boundary: `fifo_fill`=1 at ISSUE, still showing 1 in GAP → no second pulse. With `fifo_fill`=2 → second pulse exactly 2 cycles after the first.
- Simultaneous capture and accept with buffer at 3 entries and `m_ready` toggling → count unchanged, pointers wrap past BUF_DEPTH−1 correctly, data order preserved across 20+ words.
- Reset with 2 words in flight and 2 buffered → next cycle `m_valid`=0, `req_out`=0, `busy`=0. Late `fifo_rdata` values are ignored, and `ovf_err`=0.
